// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, feeds combinational imem, registers word+PC into IF/ID; FETCH_EARLY_JUMP_EN enables in-stage J.
// Latency: imem_addr to IF/ID is one edge; redirect costs one bubble, early J costs none.
// Backpressure: stall holds PC and IF/ID; redirect overrides stall and flushes IF/ID.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        if_valid,
  output logic        misalign_err
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
  } ifid_t;

  localparam logic RESET_MISALIGN = (RESET_PC[1:0] != 2'b00);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] seq_pc;
  logic [31:0] load_pc;
  logic        load_en;
  ifid_t       ifid_q;

  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;

  // Sequential successor; an unconditional J short-circuits it when enabled.
  always_comb begin
    seq_pc = pc_plus4;
`ifdef FETCH_EARLY_JUMP_EN
    if (imem_data[31:26] == 6'b000010) begin
      seq_pc = {pc_plus4[31:28], imem_data[25:0], 2'b00};
    end
`endif
  end

  always_comb begin
    load_en = redirect || !stall;
    load_pc = redirect ? redirect_pc : seq_pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= RESET_PC;
      ifid_q       <= '0;
      misalign_err <= RESET_MISALIGN;
    end else begin
      if (load_en) begin
        pc <= load_pc;
        // Misaligned PC is kept as-is; imem returns 0 for it, which flows as a NOP.
        if (load_pc[1:0] != 2'b00) begin
          misalign_err <= 1'b1;
        end
      end
      if (redirect) begin
        ifid_q.instr <= '0;
        ifid_q.valid <= 1'b0;
      end else if (!stall) begin
        ifid_q.instr    <= imem_data;
        ifid_q.pc       <= pc;
        ifid_q.pc_plus4 <= pc_plus4;
        ifid_q.valid    <= 1'b1;
      end
    end
  end

  assign if_instr    = ifid_q.instr;
  assign if_pc       = ifid_q.pc;
  assign if_pc_plus4 = ifid_q.pc_plus4;
  assign if_valid    = ifid_q.valid;

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage: owns the program counter, drives the address of the combinational instruction memory, and registers the returned word into the IF/ID pipeline register together with its PC. It sits between the instruction memory and the decode stage. It accepts stall and redirect (branch/jump resolution) from later stages. Optionally it resolves unconditional `J` instructions itself, with no bubble.

## Interface
Parameters:
- RESET_PC, 32'd0, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_addr  out  32  byte address to instruction memory; combinational copy of the PC register.
- imem_data  in  32  instruction word returned combinationally for imem_addr; zero for non-word-aligned addresses.
- stall  in  1  hold PC and IF/ID register this cycle.
- redirect  in  1  load redirect_pc and flush IF/ID this cycle.
- redirect_pc  in  32  target byte address for redirect.
- if_instr  out  32  registered instruction word.
- if_pc  out  32  registered PC of if_instr.
- if_pc_plus4  out  32  registered if_pc + 4.
- if_valid  out  1  IF/ID holds a real instruction.
- misalign_err  out  1  sticky flag: PC was loaded with nonzero bits [1:0].

## Operation
- State:
  - PC register pc, 32 bits.
  - IF/ID register: if_instr, if_pc, if_pc_plus4, if_valid.
  - Sticky misalign_err.
- imem_addr = pc at all times; no registered delay.
- pc_plus4 = pc + 32'd4, modulo 2^32. 32'hFFFFFFFC wraps to 32'h0.
- Per-edge priority, highest first:
  1. redirect:
     - pc <= redirect_pc.
     - if_valid <= 0, if_instr <= 0; if_pc and if_pc_plus4 hold.
     - Redirect overrides a simultaneous stall.
  2. stall: pc and all IF/ID outputs hold.
  3. early jump (only with macro, see Configuration):
     - Applies when imem_data[31:26] == 6'b000010.
     - pc <= {pc_plus4[31:28], imem_data[25:0], 2'b00}.
     - IF/ID captured as in normal fetch.
  4. normal fetch:
     - pc <= pc_plus4.
     - if_instr <= imem_data, if_pc <= pc, if_pc_plus4 <= pc_plus4, if_valid <= 1.
- misalign_err:
  - Set to 1 on any edge where pc is loaded with a value whose bits [1:0] != 0.
  - Cleared only by reset.
  - The bad pc is kept, not corrected. The word fetched from it is 0, a NOP, and is passed with if_valid = 1.
- No decoding beyond the opcode check for early jump. Branches (BEQ/BNE) resolve downstream and return via redirect.

## Timing
- Reset, asynchronous, immediate on rst_n low:
  - pc = RESET_PC.
  - if_instr = 0, if_pc = 0, if_pc_plus4 = 0, if_valid = 0.
  - misalign_err = 1 if RESET_PC[1:0] != 0, else 0.
- Reset asserted mid-operation discards any in-flight instruction and pending redirect.
- First valid instruction: if_valid = 1 after the first rising edge with rst_n high and no stall or redirect.
- Latency: imem_addr to if_instr is one edge. Throughput is one instruction per cycle when not stalled.
- Redirect:
  - Costs one bubble. The flushed slot has if_valid = 0.
  - The target instruction appears one edge after the redirect edge.
- Early jump: zero bubbles. The jump appears in IF/ID on the same edge the target address is presented on imem_addr.
- stall and redirect are sampled only at rising edges. Both are assumed glitch-free and synchronous to clk.

## Configuration
- FETCH_EARLY_JUMP_EN defined:
  - Priority item 3 is active. Fetch redirects on `J` itself.
  - The `J` is still delivered to decode with if_valid = 1. Decode must not redirect it again.
- Not defined:
  - `J` is treated like any other word: pc <= pc_plus4.
  - Downstream must issue redirect, costing one bubble.
- All other behaviour is identical in both builds.

## Test plan
- Reset with RESET_PC = 0: imem_addr = 0, if_valid = 0, misalign_err = 0. After releasing rst_n and 3 free edges: if_pc sequence is 0, 4, 8; if_pc_plus4 is 12 at the third edge.
- ROM with `J 26'd1` at byte 16, macro defined: imem_addr sequence is 0, 4, 8, 12, 16, 4, 8, and the `J` appears in IF/ID with if_pc = 16. Macro undefined: the sequence continues 16, 20.
- Hold stall = 1 for 2 edges at pc = 8: imem_addr stays 8 and the IF/ID outputs hold. After release, the next edge captures if_pc = 8.
- Raise redirect = 1 with redirect_pc = 32'h100 while stall = 1: next edge gives imem_addr = 32'h100 and if_valid = 0. The following edge gives if_pc = 32'h100 and if_valid = 1.
- Redirect to 32'h6: misalign_err = 1 and stays 1 through later aligned redirects. if_instr = 0 for the fetched slot. Only rst_n low clears the flag.
- Redirect to 32'hFFFFFFFC, then 2 free edges: imem_addr goes 32'hFFFFFFFC, then 32'h0. Assert rst_n low mid-sequence: all outputs return to their reset values immediately, without waiting for a clock edge.
